// File: rtl/iceram32_pkg.sv
// iceram32_pkg: default geometry shared by the iCE40-style register-file RAM.
package iceram32_pkg;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 32;
endpackage

// File: rtl/iceram32_array.sv
// iceram32_array: word storage with a per-bit masked write and a combinational read tap.
module iceram32_array
  import iceram32_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              gclk,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData,
  input  logic [DATA_W-1:0] wrMask,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic [DATA_W-1:0] rdWord
);
  // No reset on purpose: contents survive rst; register-file benches preload this array by hierarchy.
  reg [DATA_W-1:0] r_data [2**ADDR_W];
  always_ff @(posedge gclk)
    if (wrEn) r_data[wrAddr] <= (r_data[wrAddr] & wrMask) | (wrData & ~wrMask);
  assign rdWord = r_data[rdAddr];
endmodule

// File: rtl/iceram32_1clk.sv
// iceram32_1clk: single-clock simple dual-port RAM with a registered, async-cleared read port.
module iceram32_1clk
  import iceram32_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              gclk,
  input  logic              rst,
  output logic [DATA_W-1:0] RDATA,
  input  logic [ADDR_W-1:0] RADDR,
  input  logic              RE,
  input  logic              RCLKE,
  input  logic [DATA_W-1:0] WDATA,
  input  logic [DATA_W-1:0] MASK,
  input  logic [ADDR_W-1:0] WADDR,
  input  logic              WE,
  input  logic              WCLKE
);
  logic [DATA_W-1:0] rdWord;
  logic              wrEn;
  logic              rdEn;
  assign wrEn = WE && WCLKE;
  assign rdEn = RE && RCLKE;
  iceram32_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ram (
    .gclk   (gclk),
    .wrEn   (wrEn),
    .wrAddr (WADDR),
    .wrData (WDATA),
    .wrMask (MASK),
    .rdAddr (RADDR),
    .rdWord (rdWord)
  );
  // rdWord is sampled before the array updates, so a same-address write returns the old word.
  always_ff @(posedge gclk or posedge rst)
    if (rst) RDATA <= '0;
    else if (rdEn) RDATA <= rdWord;
endmodule

// File: tb/tb_iceram32_1clk.sv
// tb_iceram32_1clk: directed and randomized checks of iceram32_1clk against an array-based reference.
module tb_iceram32_1clk;
  logic        gclk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] RDATA;
  logic [7:0]  RADDR = '0;
  logic        RE = 1'b0;
  logic        RCLKE = 1'b0;
  logic [31:0] WDATA = '0;
  logic [31:0] MASK = '0;
  logic [7:0]  WADDR = '0;
  logic        WE = 1'b0;
  logic        WCLKE = 1'b0;
  logic [31:0] model [256];
  logic [31:0] expR = '0;
  int          passed = 0;
  int          total = 0;

  iceram32_1clk dut (
    .gclk(gclk), .rst(rst), .RDATA(RDATA), .RADDR(RADDR), .RE(RE), .RCLKE(RCLKE),
    .WDATA(WDATA), .MASK(MASK), .WADDR(WADDR), .WE(WE), .WCLKE(WCLKE)
  );

  always #5 gclk = ~gclk;

  // Reference: a read sees the word as it stood before this edge's write lands.
  task automatic cyc();
    if (rst) expR = '0;
    else if (RE && RCLKE) expR = model[RADDR];
    if (WE && WCLKE) model[WADDR] = (model[WADDR] & MASK) | (WDATA & ~MASK);
    @(posedge gclk);
    #1;
  endtask

  task automatic drive(input logic we, input logic wcke, input logic [7:0] wa, input logic [31:0] wd,
                       input logic [31:0] m, input logic re, input logic rcke, input logic [7:0] ra);
    WE = we; WCLKE = wcke; WADDR = wa; WDATA = wd; MASK = m;
    RE = re; RCLKE = rcke; RADDR = ra;
  endtask

  task automatic chk(input string tag, input logic [31:0] exp);
    total++;
    assert (RDATA === exp) passed++;
    else $error("FAIL %s: RDATA=%h expected=%h", tag, RDATA, exp);
  endtask

  initial begin
    #1 rst = 1'b1;
    #1 chk("reset_state", 32'h0);
    @(posedge gclk); #1;
    rst = 1'b0;
    drive(1, 1, 8'd5, 32'hDEADBEEF, 32'h0, 0, 0, 8'd0); cyc();
    drive(0, 0, 8'd0, 32'h0, 32'h0, 1, 1, 8'd5); cyc();
    chk("full_write_read", 32'hDEADBEEF);
    drive(1, 1, 8'd7, 32'hFFFFFFFF, 32'h0, 0, 0, 8'd0); cyc();
    drive(1, 1, 8'd7, 32'h0, 32'hFFFF0000, 0, 0, 8'd0); cyc();
    drive(0, 0, 8'd0, 32'h0, 32'h0, 1, 1, 8'd7); cyc();
    chk("masked_write", 32'hFFFF0000);
    drive(1, 1, 8'd3, 32'h11111111, 32'h0, 0, 0, 8'd0); cyc();
    drive(1, 1, 8'd3, 32'h22222222, 32'h0, 1, 1, 8'd3); cyc();
    chk("rdw_old", 32'h11111111);
    drive(0, 0, 8'd0, 32'h0, 32'h0, 1, 1, 8'd3); cyc();
    chk("rdw_new", 32'h22222222);
    drive(0, 0, 8'd0, 32'h0, 32'h0, 0, 1, 8'd5); cyc();
    chk("hold_re0", 32'h22222222);
    drive(0, 0, 8'd0, 32'h0, 32'h0, 1, 0, 8'd7); cyc();
    chk("hold_rclke0", 32'h22222222);
    drive(1, 1, 8'd9, 32'hAAAA5555, 32'h0, 0, 0, 8'd0); cyc();
    drive(1, 0, 8'd9, 32'h0, 32'h0, 0, 0, 8'd0); cyc();
    drive(0, 0, 8'd0, 32'h0, 32'h0, 1, 1, 8'd9); cyc();
    chk("wclke0_ignored", 32'hAAAA5555);
    drive(1, 1, 8'd4, 32'h12345678, 32'h0, 0, 0, 8'd0); cyc();
    drive(0, 0, 8'd0, 32'h0, 32'h0, 1, 1, 8'd4); cyc();
    chk("pre_reset_read", 32'h12345678);
    #3 rst = 1'b1;
    #1 chk("async_reset", 32'h0);
    drive(1, 1, 8'd6, 32'hCAFEF00D, 32'h0, 1, 1, 8'd4); cyc();
    chk("read_blocked_in_reset", 32'h0);
    drive(0, 0, 8'd0, 32'h0, 32'h0, 1, 1, 8'd4);
    #2 rst = 1'b0;
    cyc();
    chk("storage_kept", 32'h12345678);
    drive(0, 0, 8'd0, 32'h0, 32'h0, 1, 1, 8'd6); cyc();
    chk("write_during_reset", 32'hCAFEF00D);
    dut.ram.r_data[0] = 32'h0;
    dut.ram.r_data[31] = 32'h1;
    model[0] = 32'h0;
    model[31] = 32'h1;
    drive(0, 0, 8'd0, 32'h0, 32'h0, 1, 1, 8'd0); cyc();
    chk("preload_0", 32'h0);
    drive(0, 0, 8'd0, 32'h0, 32'h0, 1, 1, 8'd31); cyc();
    chk("preload_31", 32'h1);
    for (int i = 0; i < 16; i++) begin
      drive(1, 1, 8'(i), $urandom, 32'h0, 0, 0, 8'd0); cyc();
    end
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 24) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 8'($urandom_range(0, 15)),
            $urandom, ($urandom_range(0, 1) != 0) ? $urandom : 32'h0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 8'($urandom_range(0, 15)));
      cyc();
      chk("random", expR);
    end
    rst = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
